// File: rtl/alu_iterative_pkg.sv
// Shared definitions for the iterative ALU: opcode values, flag bit positions
// and the FSM state encoding. Imported by the top and the iteration unit.
package alu_iterative_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBC  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL1 = 4'h8;
    localparam logic [3:0] OP_SHR1 = 4'h9;
    localparam logic [3:0] OP_ROL  = 4'hA;
    localparam logic [3:0] OP_ROR  = 4'hB;
    localparam logic [3:0] OP_ASR1 = 4'hC;
    localparam logic [3:0] OP_SHLN = 4'hD;
    localparam logic [3:0] OP_SHRN = 4'hE;
    localparam logic [3:0] OP_MUL  = 4'hF;

    localparam int FLAG_O  = 0;
    localparam int FLAG_S  = 1;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_CA = 3;
    localparam int FLAG_CL = 4;
    localparam int FLAG_W  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // SHLN, SHRN and MUL go through the iteration engine.
    function automatic logic is_multi_cycle(input logic [3:0] op);
        return (op == OP_SHLN) || (op == OP_SHRN) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_iterative_if.sv
// Op issue / result bus between the decode stage and the ALU.
//   op_valid/op_ready : issue handshake (decode -> ALU)
//   opcode, lhs, rhs, lcarry_in, acarry_in : operation and operands
//   res_valid         : one-cycle pulse when result/result_hi/flags update
//   result, result_hi : registered result (result_hi = MUL high half, else 0)
//   flags             : [0]O [1]S [2]Z [3]CA [4]CL
// master = decode side, slave = ALU side.
interface alu_iterative_if #(
    parameter int WIDTH = 8
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
    logic             lcarry_in;
    logic             acarry_in;
    logic             res_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [4:0]       flags;

    modport master (
        output op_valid, opcode, lhs, rhs, lcarry_in, acarry_in,
        input  op_ready, res_valid, result, result_hi, flags
    );

    modport slave (
        input  op_valid, opcode, lhs, rhs, lcarry_in, acarry_in,
        output op_ready, res_valid, result, result_hi, flags
    );

endinterface

// File: rtl/alu_iterative_iter_unit.sv
// alu_iter_unit: shared iteration engine for the multi-cycle ops.
// SHLN/SHRN move one bit per cycle; MUL is a radix-2 shift-add over WIDTH
// cycles. The lo_next/hi_next/cl_next outputs are the values the current
// step produces, so the owner can capture them on the last step's edge.
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears the counter)
//   start          load operands and step count (issue edge)
//   opcode         SHLN / SHRN / MUL
//   lhs, rhs       operands; rhs[SHW-1:0] is the shift amount for shifts
//   last           current cycle performs the final step
//   lo_next        result / product low half after this step
//   hi_next        product high half after this step (0 for shifts)
//   cl_next        last bit shifted out after this step
//   mul_mode       engine currently holds a MUL
module alu_iter_unit
    import alu_iterative_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic             last,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next,
    output logic             cl_next,
    output logic             mul_mode
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    count;
    logic [CW-1:0]    load_count;
    logic [SHW-1:0]   amt;
    logic [3:0]       mode;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] mcand;
    logic             cl;
    logic             no_shift;
    logic             over_shift;
    logic [WIDTH:0]   psum;

    // Shift steps: amount 0 still takes one (null) step; amounts beyond
    // WIDTH are clamped to WIDTH steps, which already clears the result.
    always_comb begin
        amt = rhs[SHW-1:0];
        if (opcode == OP_MUL) begin
            load_count = CW'(WIDTH);
        end else if (amt == '0) begin
            load_count = CW'(1);
        end else if (amt > SHW'(WIDTH)) begin
            load_count = CW'(WIDTH);
        end else begin
            load_count = CW'(amt);
        end
    end

    always_comb begin
        lo_next = acc_lo;
        hi_next = acc_hi;
        cl_next = cl;
        psum    = '0;
        case (mode)
            OP_MUL: begin
                // Add multiplicand when the multiplier LSB is set, then shift the
                // {hi, lo} pair right; the multiplier drains out of lo as the
                // product bits shift in.
                psum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
                {hi_next, lo_next} = {psum, acc_lo[WIDTH-1:1]};
            end
            OP_SHLN: begin
                if (no_shift) begin
                    cl_next = 1'b0;
                end else begin
                    lo_next = {acc_lo[WIDTH-2:0], 1'b0};
                    cl_next = over_shift ? 1'b0 : acc_lo[WIDTH-1];
                end
            end
            OP_SHRN: begin
                if (no_shift) begin
                    cl_next = 1'b0;
                end else begin
                    lo_next = {1'b0, acc_lo[WIDTH-1:1]};
                    cl_next = over_shift ? 1'b0 : acc_lo[0];
                end
            end
            default: ;
        endcase
    end

    assign last     = (count == CW'(1));
    assign mul_mode = (mode == OP_MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= load_count;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            mode       <= opcode;
            acc_lo     <= (opcode == OP_MUL) ? rhs : lhs;
            acc_hi     <= '0;
            mcand      <= lhs;
            cl         <= 1'b0;
            no_shift   <= (amt == '0);
            over_shift <= (amt > SHW'(WIDTH));
        end else if (count != '0) begin
            acc_lo <= lo_next;
            acc_hi <= hi_next;
            cl     <= cl_next;
        end
    end

endmodule

// File: rtl/alu_iterative.sv
// alu_iterative: handshaked WIDTH-bit ALU with registered result and flags.
// Ops 0..C complete in one cycle (back-to-back issue allowed); SHLN, SHRN
// and MUL run in alu_iter_unit while op_ready is held low.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bus         alu_iterative_if slave: op issue handshake, operands, result,
//               result_hi, flags, res_valid
//   alu_assert  active low: drive result onto main_bus
//   main_bus    shared bus; result when alu_assert==0, else high-Z
module alu_iterative #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    alu_iterative_if.slave  bus,
    input  logic            alu_assert,
    inout  wire [WIDTH-1:0] main_bus
);
    import alu_iterative_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  result_q;
    logic [WIDTH-1:0]  result_hi_q;
    logic [FLAG_W-1:0] flags_q;
    logic              res_valid_q;

    logic              accept;
    logic              start_multi;
    logic              run_done;
    logic              iter_last;
    logic [WIDTH-1:0]  iter_lo;
    logic [WIDTH-1:0]  iter_hi;
    logic              iter_cl;
    logic              iter_mul;

    logic [WIDTH-1:0]  sc_result;
    logic [FLAG_W-1:0] sc_flags;
    logic [FLAG_W-1:0] mc_flags;
    logic [WIDTH:0]    add_sum;
    logic [WIDTH-1:0]  add_rhs;
    logic              add_cin;

    function automatic logic signed_overflow(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b,
        input logic signed [WIDTH-1:0] r
    );
        return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
    endfunction

    assign bus.op_ready  = (state == ST_IDLE);
    assign accept        = bus.op_valid && bus.op_ready;
    assign start_multi   = accept && is_multi_cycle(bus.opcode);
    assign run_done      = (state == ST_RUN) && iter_last;

    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flags     = flags_q;
    assign bus.res_valid = res_valid_q;

    assign main_bus = alu_assert ? 'z : result_q;

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (start_multi),
        .opcode   (bus.opcode),
        .lhs      (bus.lhs),
        .rhs      (bus.rhs),
        .last     (iter_last),
        .lo_next  (iter_lo),
        .hi_next  (iter_hi),
        .cl_next  (iter_cl),
        .mul_mode (iter_mul)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_multi) state_next = ST_RUN;
            ST_RUN:  if (iter_last)   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Single-cycle datapath; flags not touched by an op keep their value.
    always_comb begin
        sc_result = '0;
        sc_flags  = flags_q;
        add_rhs   = bus.rhs;
        add_cin   = 1'b0;
        add_sum   = '0;
        case (bus.opcode)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                // Subtraction is LHS + ~RHS + cin, so CA=1 means no borrow.
                if (bus.opcode == OP_SUB || bus.opcode == OP_SBC) add_rhs = ~bus.rhs;
                if (bus.opcode == OP_SUB) begin
                    add_cin = 1'b1;
                end else if (bus.opcode != OP_ADD) begin
                    add_cin = bus.acarry_in;
                end
                add_sum = {1'b0, bus.lhs} + {1'b0, add_rhs} + {{WIDTH{1'b0}}, add_cin};
                sc_result = add_sum[WIDTH-1:0];
                sc_flags[FLAG_CA] = add_sum[WIDTH];
                sc_flags[FLAG_O]  = signed_overflow(bus.lhs, add_rhs, sc_result);
            end
            OP_AND: sc_result = bus.lhs & bus.rhs;
            OP_OR:  sc_result = bus.lhs | bus.rhs;
            OP_XOR: sc_result = bus.lhs ^ bus.rhs;
            OP_NOT: sc_result = ~bus.lhs;
            OP_SHL1: begin
                sc_result = {bus.lhs[WIDTH-2:0], 1'b0};
                sc_flags[FLAG_CL] = bus.lhs[WIDTH-1];
            end
            OP_SHR1: begin
                sc_result = {1'b0, bus.lhs[WIDTH-1:1]};
                sc_flags[FLAG_CL] = bus.lhs[0];
            end
            OP_ROL: begin
                sc_result = {bus.lhs[WIDTH-2:0], bus.lcarry_in};
                sc_flags[FLAG_CL] = bus.lhs[WIDTH-1];
            end
            OP_ROR: begin
                sc_result = {bus.lcarry_in, bus.lhs[WIDTH-1:1]};
                sc_flags[FLAG_CL] = bus.lhs[0];
            end
            OP_ASR1: begin
                sc_result = {bus.lhs[WIDTH-1], bus.lhs[WIDTH-1:1]};
                sc_flags[FLAG_CL] = bus.lhs[0];
            end
            default: ;
        endcase
        sc_flags[FLAG_S] = sc_result[WIDTH-1];
        sc_flags[FLAG_Z] = (sc_result == '0);
    end

    // Flags for the value the engine produces on its final step.
    always_comb begin
        mc_flags = flags_q;
        if (iter_mul) begin
            mc_flags[FLAG_S]  = iter_hi[WIDTH-1];
            mc_flags[FLAG_Z]  = (iter_hi == '0) && (iter_lo == '0);
            mc_flags[FLAG_CA] = (iter_hi != '0);
        end else begin
            mc_flags[FLAG_S]  = iter_lo[WIDTH-1];
            mc_flags[FLAG_Z]  = (iter_lo == '0);
            mc_flags[FLAG_CL] = iter_cl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            if (accept && !is_multi_cycle(bus.opcode)) begin
                result_q    <= sc_result;
                result_hi_q <= '0;
                flags_q     <= sc_flags;
                res_valid_q <= 1'b1;
            end else if (run_done) begin
                result_q    <= iter_lo;
                result_hi_q <= iter_hi;
                flags_q     <= mc_flags;
                res_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative (WIDTH=8): each issued op pushes its
// expected result/flags/latency, a monitor records every res_valid pulse,
// and each scenario task pops and compares the pairs.
module tb_alu_iterative;
    import alu_iterative_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         alu_assert = 1'b1;
    wire  [W-1:0] main_bus;

    alu_iterative_if #(.WIDTH(W)) bif ();

    alu_iterative #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bif),
        .alu_assert (alu_assert),
        .main_bus   (main_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic [4:0] flags;
        int         lat;
        int         acc_cyc;
    } exp_t;

    typedef struct {
        logic [7:0] res;
        logic [7:0] hi;
        logic [4:0] flags;
        int         cyc;
    } got_t;

    exp_t       exp_q[$];
    got_t       got_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [4:0] model_flags = 5'b0;
    int         last_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        got_t g;
        if (bif.res_valid === 1'b1) begin
            g.res   = bif.result;
            g.hi    = bif.result_hi;
            g.flags = bif.flags;
            g.cyc   = cyc;
            got_q.push_back(g);
        end
    end

    // Reference behaviour: plain integer arithmetic, wide shifts and '*'.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic lc, input logic ac, input logic [4:0] pf);
        exp_t        e;
        logic [8:0]  full;
        logic [15:0] wide;
        logic [7:0]  nb;
        logic        c;
        int          s;
        int          amt;
        e.res = 8'h00; e.hi = 8'h00; e.flags = pf; e.lat = 1; e.acc_cyc = 0;
        amt = int'(b[3:0]);
        wide = 16'h0;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3: begin
                nb = (op >= 4'h2) ? ~b : b;
                c  = (op == 4'h0) ? 1'b0 : (op == 4'h2) ? 1'b1 : ac;
                full = {1'b0, a} + {1'b0, nb} + {8'h00, c};
                e.res = full[7:0];
                e.flags[3] = full[8];
                if (op < 4'h2) s = int'($signed(a)) + int'($signed(b)) + int'(c);
                else           s = int'($signed(a)) - int'($signed(b)) - (1 - int'(c));
                e.flags[0] = (s > 127) || (s < -128);
            end
            4'h4: e.res = a & b;
            4'h5: e.res = a | b;
            4'h6: e.res = a ^ b;
            4'h7: e.res = ~a;
            4'h8: begin e.res = a << 1; e.flags[4] = a[7]; end
            4'h9: begin e.res = a >> 1; e.flags[4] = a[0]; end
            4'hA: begin e.res = {a[6:0], lc}; e.flags[4] = a[7]; end
            4'hB: begin e.res = {lc, a[7:1]}; e.flags[4] = a[0]; end
            4'hC: begin e.res = {a[7], a[7:1]}; e.flags[4] = a[0]; end
            4'hD: begin
                wide = {8'h00, a} << amt;
                e.res = wide[7:0];
                e.flags[4] = (amt >= 1 && amt <= 8) ? wide[8] : 1'b0;
                e.lat = (amt == 0) ? 2 : (amt > 8) ? 9 : amt + 1;
            end
            4'hE: begin
                wide = {a, 8'h00} >> amt;
                e.res = wide[15:8];
                e.flags[4] = (amt >= 1 && amt <= 8) ? wide[7] : 1'b0;
                e.lat = (amt == 0) ? 2 : (amt > 8) ? 9 : amt + 1;
            end
            default: begin
                wide = 16'(a) * 16'(b);
                e.res = wide[7:0];
                e.hi  = wide[15:8];
                e.lat = 9;
            end
        endcase
        if (op == 4'hF) begin
            e.flags[1] = e.hi[7];
            e.flags[2] = (wide == 16'h0);
            e.flags[3] = (e.hi != 8'h00);
        end else begin
            e.flags[1] = e.res[7];
            e.flags[2] = (e.res == 8'h00);
        end
        return e;
    endfunction

    // Present an op, hold it until accepted, and record its expectation.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic lc, input logic ac);
        exp_t e;
        int   waitc;
        waitc = 0;
        @(negedge clk);
        bif.op_valid  = 1'b1;
        bif.opcode    = op;
        bif.lhs       = a;
        bif.rhs       = b;
        bif.lcarry_in = lc;
        bif.acarry_in = ac;
        while (bif.op_ready !== 1'b1 && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        if (bif.op_ready !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL issue_accept op=%h op_ready=%b required 1 within 40 cycles", op, bif.op_ready);
            bif.op_valid = 1'b0;
            return;
        end
        e = model(op, a, b, lc, ac, model_flags);
        model_flags = e.flags;
        @(posedge clk);
        #1;
        e.acc_cyc = cyc;
        last_acc_cyc = cyc;
        exp_q.push_back(e);
        bif.op_valid = 1'b0;
    endtask

    // Wait (bounded) for a captured result and pop it with its expectation.
    task automatic take(output exp_t e, output got_t g, output bit ok);
        int t;
        t = 0;
        e = '{8'h00, 8'h00, 5'h00, 0, 0};
        g = '{8'hxx, 8'hxx, 5'hxx, -1};
        while (got_q.size() == 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        ok = (got_q.size() != 0) && (exp_q.size() != 0);
        if (ok) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.result !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h required 00", bif.result); end
        n_cmp++; if (bif.result_hi !== 8'h00) begin n_fail++; $display("FAIL reset_hi got %h required 00", bif.result_hi); end
        n_cmp++; if (bif.flags !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b required 00000", bif.flags); end
        n_cmp++; if (bif.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b required 0", bif.res_valid); end
        n_cmp++; if (bif.op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_op_ready got %b required 1", bif.op_ready); end
        model_flags = 5'b0;
    endtask

    task automatic test_add_sub();
        exp_t e; got_t g; bit ok;
        logic [7:0] want_res [3];
        logic [4:0] want_flags [3];
        want_res[0] = 8'h80; want_flags[0] = 5'b00011;
        want_res[1] = 8'hF0; want_flags[1] = 5'b00010;
        want_res[2] = 8'hFF; want_flags[2] = 5'b00010;
        issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
        issue(OP_SUB, 8'h10, 8'h20, 1'b0, 1'b0);
        issue(OP_SBC, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            take(e, g, ok);
            n_cmp++;
            if (!ok || g.res !== want_res[i] || g.flags !== want_flags[i] || g.hi !== 8'h00
                || (g.cyc - e.acc_cyc + 1) != 1) begin
                n_fail++;
                $display("FAIL arith_%0d res=%h flags=%b hi=%h lat=%0d required res=%h flags=%b hi=00 lat=1",
                         i, g.res, g.flags, g.hi, g.cyc - e.acc_cyc + 1, want_res[i], want_flags[i]);
            end
            n_cmp++;
            if (g.res !== e.res || g.flags !== e.flags) begin
                n_fail++;
                $display("FAIL arith_model_%0d res=%h flags=%b required res=%h flags=%b", i, g.res, g.flags, e.res, e.flags);
            end
        end
    endtask

    task automatic test_single_ops();
        exp_t e; got_t g; bit ok;
        logic [3:0] op;
        for (int i = 0; i < 26; i++) begin
            op = 4'(i % 13);
            issue(op, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            take(e, g, ok);
            n_cmp++;
            if (!ok || g.res !== e.res || g.hi !== e.hi || g.flags !== e.flags || (g.cyc - e.acc_cyc + 1) != e.lat) begin
                n_fail++;
                $display("FAIL single_op_%h res=%h hi=%h flags=%b lat=%0d required res=%h hi=%h flags=%b lat=%0d",
                         op, g.res, g.hi, g.flags, g.cyc - e.acc_cyc + 1, e.res, e.hi, e.flags, e.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; got_t g; bit ok;
        int first_acc;
        logic [3:0] ops [4];
        ops[0] = OP_ADC; ops[1] = OP_XOR; ops[2] = OP_ROR; ops[3] = OP_ASR1;
        first_acc = 0;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], 8'($urandom), 8'($urandom), 1'b1, 1'b1);
            if (i == 0) first_acc = last_acc_cyc;
        end
        for (int i = 0; i < 4; i++) begin
            take(e, g, ok);
            n_cmp++;
            if (!ok || g.res !== e.res || g.flags !== e.flags || (g.cyc - e.acc_cyc + 1) != 1
                || e.acc_cyc != first_acc + i) begin
                n_fail++;
                $display("FAIL b2b_%0d res=%h flags=%b lat=%0d acc=%0d required res=%h flags=%b lat=1 acc=%0d",
                         i, g.res, g.flags, g.cyc - e.acc_cyc + 1, e.acc_cyc, e.res, e.flags, first_acc + i);
            end
        end
    endtask

    task automatic test_mul();
        exp_t e; got_t g; bit ok;
        int low_cnt;
        issue(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0);
        low_cnt = 0;
        @(negedge clk);
        while (bif.op_ready !== 1'b1 && low_cnt < 50) begin
            low_cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (low_cnt != 8) begin n_fail++; $display("FAIL mul_ready_low got %0d cycles required 8", low_cnt); end
        take(e, g, ok);
        n_cmp++;
        if (!ok || g.hi !== 8'hFE || g.res !== 8'h01 || g.flags[FLAG_CA] !== 1'b1 || (g.cyc - e.acc_cyc + 1) != 9) begin
            n_fail++;
            $display("FAIL mul_ff_ff hi=%h lo=%h ca=%b lat=%0d required hi=fe lo=01 ca=1 lat=9",
                     g.hi, g.res, g.flags[FLAG_CA], g.cyc - e.acc_cyc + 1);
        end
        n_cmp++;
        if (g.flags !== e.flags) begin n_fail++; $display("FAIL mul_flags got %b required %b", g.flags, e.flags); end
        for (int i = 0; i < 3; i++) begin
            issue(OP_MUL, (i == 0) ? 8'h00 : 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            take(e, g, ok);
            n_cmp++;
            if (!ok || g.res !== e.res || g.hi !== e.hi || g.flags !== e.flags || (g.cyc - e.acc_cyc + 1) != e.lat) begin
                n_fail++;
                $display("FAIL mul_%0d hi=%h lo=%h flags=%b lat=%0d required hi=%h lo=%h flags=%b lat=%0d",
                         i, g.hi, g.res, g.flags, g.cyc - e.acc_cyc + 1, e.hi, e.res, e.flags, e.lat);
            end
        end
    endtask

    task automatic test_shift_n();
        exp_t e; got_t g; bit ok;
        logic [3:0] sop  [8];
        logic [7:0] sa   [8];
        logic [7:0] sb   [8];
        logic [7:0] wres [8];
        logic       wcl  [8];
        int         wlat [8];
        sop[0] = OP_SHLN; sa[0] = 8'h81; sb[0] = 8'h01; wres[0] = 8'h02; wcl[0] = 1'b1; wlat[0] = 2;
        sop[1] = OP_SHLN; sa[1] = 8'h81; sb[1] = 8'h08; wres[1] = 8'h00; wcl[1] = 1'b1; wlat[1] = 9;
        sop[2] = OP_SHLN; sa[2] = 8'h81; sb[2] = 8'h09; wres[2] = 8'h00; wcl[2] = 1'b0; wlat[2] = 9;
        sop[3] = OP_SHLN; sa[3] = 8'hA5; sb[3] = 8'h00; wres[3] = 8'hA5; wcl[3] = 1'b0; wlat[3] = 2;
        sop[4] = OP_SHRN; sa[4] = 8'hB4; sb[4] = 8'h03; wres[4] = 8'h16; wcl[4] = 1'b1; wlat[4] = 4;
        sop[5] = OP_SHRN; sa[5] = 8'h81; sb[5] = 8'h08; wres[5] = 8'h00; wcl[5] = 1'b1; wlat[5] = 9;
        sop[6] = OP_SHRN; sa[6] = 8'hFF; sb[6] = 8'hF0; wres[6] = 8'hFF; wcl[6] = 1'b0; wlat[6] = 2;
        sop[7] = OP_SHLN; sa[7] = 8'h3C; sb[7] = 8'h0F; wres[7] = 8'h00; wcl[7] = 1'b0; wlat[7] = 9;
        for (int i = 0; i < 8; i++) begin
            issue(sop[i], sa[i], sb[i], 1'b0, 1'b0);
            take(e, g, ok);
            n_cmp++;
            if (!ok || g.res !== wres[i] || g.flags[FLAG_CL] !== wcl[i] || g.hi !== 8'h00
                || g.flags[FLAG_Z] !== (wres[i] == 8'h00) || (g.cyc - e.acc_cyc + 1) != wlat[i]) begin
                n_fail++;
                $display("FAIL shiftn_%0d res=%h cl=%b z=%b hi=%h lat=%0d required res=%h cl=%b z=%b hi=00 lat=%0d",
                         i, g.res, g.flags[FLAG_CL], g.flags[FLAG_Z], g.hi, g.cyc - e.acc_cyc + 1,
                         wres[i], wcl[i], (wres[i] == 8'h00), wlat[i]);
            end
            n_cmp++;
            if (g.flags !== e.flags) begin n_fail++; $display("FAIL shiftn_flags_%0d got %b required %b", i, g.flags, e.flags); end
        end
    endtask

    task automatic test_reset_during_run();
        exp_t e; got_t g; bit ok;
        int mul_acc;
        issue(OP_MUL, 8'hA5, 8'h3C, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(exp_q.pop_back());
        model_flags = 5'b0;
        n_cmp++; if (bif.op_ready !== 1'b1) begin n_fail++; $display("FAIL rstrun_op_ready got %b required 1", bif.op_ready); end
        n_cmp++; if (bif.flags !== 5'b0) begin n_fail++; $display("FAIL rstrun_flags got %b required 00000", bif.flags); end
        n_cmp++; if (bif.result !== 8'h00 || bif.result_hi !== 8'h00) begin
            n_fail++; $display("FAIL rstrun_result got %h:%h required 00:00", bif.result_hi, bif.result);
        end
        repeat (12) @(negedge clk);
        n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rstrun_no_valid got %0d pulses required 0", got_q.size()); got_q.delete(); end
        issue(OP_MUL, 8'h0C, 8'h0D, 1'b0, 1'b0);
        mul_acc = last_acc_cyc;
        issue(OP_ADD, 8'h01, 8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            take(e, g, ok);
            n_cmp++;
            if (!ok || g.res !== e.res || g.hi !== e.hi || g.flags !== e.flags || g.cyc != mul_acc + 8 + i) begin
                n_fail++;
                $display("FAIL held_valid_%0d res=%h hi=%h flags=%b cyc=%0d required res=%h hi=%h flags=%b cyc=%0d",
                         i, g.res, g.hi, g.flags, g.cyc, e.res, e.hi, e.flags, mul_acc + 8 + i);
            end
        end
    endtask

    task automatic test_mainbus();
        exp_t e; got_t g; bit ok;
        alu_assert = 1'b1;
        issue(OP_AND, 8'hF0, 8'h3C, 1'b0, 1'b0);
        take(e, g, ok);
        n_cmp++;
        if (!ok || g.res !== 8'h30 || g.flags !== e.flags) begin
            n_fail++; $display("FAIL and_result res=%h flags=%b required res=30 flags=%b", g.res, g.flags, e.flags);
        end
        @(negedge clk);
        n_cmp++; if (main_bus === 8'h30) begin n_fail++; $display("FAIL bus_released got %h required high-Z", main_bus); end
        alu_assert = 1'b0;
        #1;
        n_cmp++; if (main_bus !== 8'h30) begin n_fail++; $display("FAIL bus_driven got %h required 30", main_bus); end
        alu_assert = 1'b1;
        #1;
        n_cmp++; if (main_bus === 8'h30) begin n_fail++; $display("FAIL bus_rereleased got %h required high-Z", main_bus); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bif.op_valid  = 1'b0;
        bif.opcode    = 4'h0;
        bif.lhs       = 8'h00;
        bif.rhs       = 8'h00;
        bif.lcarry_in = 1'b0;
        bif.acarry_in = 1'b0;
        test_reset();
        test_add_sub();
        test_single_ops();
        test_back_to_back();
        test_mul();
        test_shift_n();
        test_reset_during_run();
        test_mainbus();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
